dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 1024, meaning the number of 32-bit words in the data memory.
REQ-002 The module SHALL have parameter ADDRESS_SIZE, default 32, meaning the address and data width.
REQ-003 The module SHALL have parameter WAIT_STATES, default 2, meaning the extra cycles per access (legal range 0..15).
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-005 The module SHALL have port RESET, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The module SHALL have port MemRead, input, 1 bit: the core's read request, held until READY.
REQ-007 The module SHALL have port MemWrite, input, 1 bit: the core's write request, held until READY.
REQ-008 The module SHALL have port daddr, input, ADDRESS_SIZE bits: the byte address.
REQ-009 The module SHALL have port ddata_w, input, ADDRESS_SIZE bits: the write data.
REQ-010 The module SHALL have port ddata_r, output, ADDRESS_SIZE bits: the registered read data, valid when READY is high.
REQ-011 The module SHALL have port READY, output, 1 bit: a one-cycle pulse that completes the accepted access.
REQ-012 The module SHALL have port STALL, output, 1 bit: combinational, equal to (MemRead|MemWrite) & ~READY, driving the core's pipeline freeze.
REQ-013 The module SHALL have port ERR, output, 1 bit: a misaligned-access flag that is valid with READY.

Function
REQ-014 The state machine SHALL have the states IDLE, BUSY and DONE.
REQ-015 In IDLE with MemRead|MemWrite high at a rising edge, the module SHALL accept the access by latching daddr, ddata_w and the operation, then go to BUSY if WAIT_STATES>0, else to DONE.
REQ-016 In BUSY, a counter SHALL load WAIT_STATES-1 on acceptance and decrement each cycle, and the module SHALL go to DONE on the edge where the counter reads 0.
REQ-017 The write commit and read-data capture SHALL both occur on the edge that enters DONE.
REQ-018 READY SHALL be high for exactly the one cycle in DONE, so latency is WAIT_STATES+1 cycles from the acceptance edge to READY high.
REQ-019 DONE SHALL always return to IDLE on the next edge, and requests present in DONE SHALL NOT be accepted; the earliest back-to-back acceptance is the cycle after READY.
REQ-020 Requests arriving in BUSY or DONE, and changes to daddr or ddata_w after acceptance, SHALL be ignored.
REQ-021 If MemRead and MemWrite are both high, the write SHALL take priority and ddata_r SHALL hold its previous value.
REQ-022 The word index SHALL be daddr[$clog2(DATA_SIZE)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DATA_SIZE words.
REQ-023 ddata_r SHALL hold its last captured value in all non-DONE cycles.
REQ-024 Memory contents SHALL be undefined until they are written.

Reset
REQ-025 While RESET is high, the module SHALL asynchronously force state=IDLE, counter=0, READY=0, ddata_r=0 and ERR=0.
REQ-026 Reset SHALL NOT clear the memory array.
REQ-027 A reset asserted mid-access SHALL abort the access; an uncommitted write SHALL NOT reach the array.
REQ-028 The first acceptance after reset SHALL be possible on the first rising edge after RESET deasserts.

Configuration
REQ-029 With DMEM_MISALIGN_ERR_EN defined, an access with latched daddr[1:0]!=0 SHALL suppress the write, force ddata_r=0 and assert ERR together with READY.
REQ-030 Without DMEM_MISALIGN_ERR_EN, ERR SHALL be tied to 0 and daddr[1:0] SHALL be ignored.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state enum (IDLE, BUSY, DONE), the DATA_SIZE default and the word-index width constant.
REQ-032 The storage SHALL be one sub-module, dmem_array: a single-port synchronous RAM with write enable and registered read.
REQ-033 The FSM, counter and handshake logic SHALL stay in dmem_responder.

Verification
REQ-034 Write-then-read, WAIT_STATES=2: MemWrite, daddr=0x10, ddata_w=0xDEADBEEF -> READY on the 3rd cycle after acceptance; then MemRead at 0x10 -> ddata_r=0xDEADBEEF with READY.
REQ-035 Wrap-around: write 0x12345678 at daddr=0x1004, then read daddr=0x0004 -> ddata_r=0x12345678.
REQ-036 Simultaneous request: MemRead=MemWrite=1, daddr=0x20, ddata_w=0xA5A5A5A5 -> the write is committed and ddata_r is unchanged; a following read at 0x20 returns 0xA5A5A5A5.
REQ-037 Reset mid-op: assert RESET during BUSY of a write of 0x11111111 to 0x30, where 0x30 previously held 0x22222222 -> READY never pulses, outputs are 0, and a later read at 0x30 returns 0x22222222.
REQ-038 Back-to-back with WAIT_STATES=0: hold MemRead for two accesses -> READY pulses on alternate cycles and STALL is high exactly in the non-READY request cycles.
REQ-039 Misalignment with DMEM_MISALIGN_ERR_EN defined: read at daddr=0x13 -> ERR=1, READY=1, ddata_r=0; without the macro -> ERR stays 0 and the data of 0x10 is returned.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the dmem_responder slice   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int word_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int c_DATA_SIZE_DEF = 1024;
  localparam int c_WORD_IDX_W    = word_idx_w(c_DATA_SIZE_DEF);

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array : single-port synchronous RAM, write enable, registered   |
// |              read port (only the read register is reset)             |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = c_DATA_SIZE_DEF,
  parameter int IDX_W  = c_WORD_IDX_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_rzero,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : wait-state data memory with READY/STALL handshake.  |
// | Optional DMEM_MISALIGN_ERR_EN flags misaligned accesses on ERR.      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_SIZE    = c_DATA_SIZE_DEF,
  parameter int ADDRESS_SIZE = 32,
  parameter int WAIT_STATES  = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [ADDRESS_SIZE-1:0] daddr,
  input  logic [ADDRESS_SIZE-1:0] ddata_w,
  output logic [ADDRESS_SIZE-1:0] ddata_r,
  output logic                    READY,
  output logic                    STALL,
  output logic                    ERR
);

  localparam int         c_IDX_W    = word_idx_w(DATA_SIZE);
  localparam logic [3:0] c_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [c_IDX_W-1:0]      r_idx;
  logic [c_IDX_W-1:0]      w_idx;
  logic [ADDRESS_SIZE-1:0] r_wdata;
  logic [ADDRESS_SIZE-1:0] w_wdata;
  logic                    r_wr;
  logic                    w_wr;
  logic                    w_req;
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_mis;
  logic                    w_ready;
  logic                    w_unused_addr;

  assign w_req    = MemRead | MemWrite;
  assign w_accept = (r_state == IDLE) & w_req;

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the live inputs must feed the array while still in IDLE.
  assign w_idx   = (r_state == IDLE) ? daddr[c_IDX_W+1:2] : r_idx;
  assign w_wdata = (r_state == IDLE) ? ddata_w : r_wdata;
  assign w_wr    = (r_state == IDLE) ? MemWrite : r_wr;

  // Gating with RESET keeps an in-flight write out of the array.
  assign w_commit = (w_next == DONE) & ~RESET;

`ifdef DMEM_MISALIGN_ERR_EN
  logic [1:0] r_lo;
  logic [1:0] w_lo;

  assign w_lo  = (r_state == IDLE) ? daddr[1:0] : r_lo;
  assign w_mis = (w_lo != 2'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lo <= 2'd0;
    end else if (w_accept) begin
      r_lo <= daddr[1:0];
    end
  end
`else
  assign w_mis = 1'b0;
`endif

  assign w_unused_addr = ^{daddr[ADDRESS_SIZE-1:c_IDX_W+2], daddr[1:0]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = (WAIT_STATES > 0) ? BUSY : DONE;
      BUSY:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state == DONE);
    READY   = w_ready;
    STALL   = w_req & ~w_ready;
`ifdef DMEM_MISALIGN_ERR_EN
    ERR     = w_ready & (r_lo != 2'd0);
`else
    ERR     = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_CNT_LOAD;
    end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= daddr[c_IDX_W+1:2];
      r_wdata <= ddata_w;
      r_wr    <= MemWrite;
    end
  end

  // A write-with-read leaves ddata_r alone; a misaligned access zeroes it.
  dmem_array #(
    .DEPTH  (DATA_SIZE),
    .IDX_W  (c_IDX_W),
    .DATA_W (ADDRESS_SIZE)
  ) u_array (
    .clk     (CLK),
    .rst     (RESET),
    .i_we    (w_commit & w_wr & ~w_mis),
    .i_re    (w_commit & (~w_wr | w_mis)),
    .i_rzero (w_mis),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (ddata_r)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder : randomized self-checking bench, two instances    |
// |                     (WAIT_STATES=2 and WAIT_STATES=0)                |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int c_WS_A = 2;
  localparam int c_WS_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        stall [2];
  logic        err   [2];

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model [2][1024];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_SIZE(1024), .ADDRESS_SIZE(32), .WAIT_STATES(c_WS_A)) u_dut_a (
    .CLK(clk), .RESET(rst), .MemRead(rd[0]), .MemWrite(wr[0]), .daddr(addr[0]),
    .ddata_w(wdata[0]), .ddata_r(rdata[0]), .READY(ready[0]), .STALL(stall[0]), .ERR(err[0])
  );

  dmem_responder #(.DATA_SIZE(1024), .ADDRESS_SIZE(32), .WAIT_STATES(c_WS_B)) u_dut_b (
    .CLK(clk), .RESET(rst), .MemRead(rd[1]), .MemWrite(wr[1]), .daddr(addr[1]),
    .ddata_w(wdata[1]), .ddata_r(rdata[1]), .READY(ready[1]), .STALL(stall[1]), .ERR(err[1])
  );

  // One complete access on instance s; expectations come from the word-array model.
  task automatic access(input int s, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int          idx;
    bit          mis;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          n;
    bit          seen;
    idx = int'((a / 4) % 1024);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    mis = (a % 4) != 0;
`endif
    exp_lat = ((s == 0) ? c_WS_A : c_WS_B) + 1;
    if (mis) begin
      exp_rd = '0;
    end else if (w) begin
      exp_rd = last_rd[s];
      model[s][idx] = d;
    end else begin
      exp_rd = model[s][idx];
    end
    rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
    #1;
    n_cmp++;
    if (stall[s] !== 1'b1 || ready[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pre_accept dut%0d: stall=%b ready=%b want stall=1 ready=0", tag, s, stall[s], ready[s]);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (ready[s] === 1'b1) begin
        seen = 1'b1;
      end else begin
        n_cmp++;
        if (stall[s] !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall_wait dut%0d cycle %0d: got %b want 1", tag, s, n, stall[s]);
        end
        addr[s] = $urandom; wdata[s] = $urandom;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s ready_timeout dut%0d: no READY within %0d cycles", tag, s, n);
    end else begin
      if (n != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency dut%0d: got %0d want %0d", tag, s, n, exp_lat);
      end
      n_cmp++;
      if (rdata[s] !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata dut%0d: got %h want %h", tag, s, rdata[s], exp_rd);
      end
      n_cmp++;
      if (err[s] !== mis) begin
        n_fail++;
        $display("FAIL %s err dut%0d: got %b want %b", tag, s, err[s], mis);
      end
      n_cmp++;
      if (stall[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall_ready dut%0d: got %b want 0", tag, s, stall[s]);
      end
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
    last_rd[s] = exp_rd;
    @(posedge clk); #1;
    n_cmp++;
    if (ready[s] !== 1'b0 || rdata[s] !== exp_rd || err[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_pulse dut%0d: ready=%b rdata=%h err=%b want 0/%h/0", tag, s, ready[s], rdata[s], err[s], exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      last_rd[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (ready[s] !== 1'b0 || rdata[s] !== 32'h0 || err[s] !== 1'b0 || stall[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: ready=%b rdata=%h err=%b stall=%b want all 0", s, ready[s], rdata[s], err[s], stall[s]);
      end
    end
    rd[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (stall[0] !== 1'b1 || ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: stall=%b ready=%b want 1/0", stall[0], ready[0]);
    end
    rd[0] = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, "wr_0x10");
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, "rd_0x10");
  endtask

  task automatic test_wrap();
    access(0, 1'b1, 1'b0, 32'h1004, 32'h1234_5678, "wrap_wr");
    access(0, 1'b0, 1'b1, 32'h0004, 32'h0, "wrap_rd");
  endtask

  task automatic test_simultaneous();
    access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, "both_req");
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, "both_followup_rd");
  endtask

  task automatic test_reset_midop();
    access(0, 1'b1, 1'b0, 32'h30, 32'h2222_2222, "midop_prefill");
    wr[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h1111_1111;
    @(posedge clk); #1;
    n_cmp++;
    if (ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_busy_ready: got %b want 0", ready[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ready[0] !== 1'b0 || rdata[0] !== 32'h0 || err[0] !== 1'b0 || rdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL midop_async_reset: ready=%b rdata=%h err=%b rdata_b=%h want 0", ready[0], rdata[0], err[0], rdata[1]);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_ready_in_reset cycle %0d: got %b want 0", k, ready[0]);
      end
    end
    wr[0] = 1'b0;
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    access(0, 1'b0, 1'b1, 32'h30, 32'h0, "midop_readback");
  endtask

  task automatic test_misalign();
    access(0, 1'b1, 1'b0, 32'h10, 32'h0BAD_F00D, "mis_prefill");
    access(0, 1'b0, 1'b1, 32'h13, 32'h0, "mis_rd_0x13");
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1;
    logic [31:0] v2;
    logic        exp_rdy;
    v1 = $urandom;
    v2 = $urandom;
    access(1, 1'b1, 1'b0, 32'h40, v1, "b2b_fill0");
    access(1, 1'b1, 1'b0, 32'h44, v2, "b2b_fill1");
    rd[1] = 1'b1; addr[1] = 32'h40;
    #1;
    n_cmp++;
    if (stall[1] !== 1'b1 || ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start: stall=%b ready=%b want 1/0", stall[1], ready[1]);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      exp_rdy = (k % 2 == 0);
      n_cmp++;
      if (ready[1] !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_ready cycle %0d: got %b want %b", k, ready[1], exp_rdy);
      end
      if (exp_rdy) begin
        n_cmp++;
        if (rdata[1] !== ((k == 0) ? v1 : v2)) begin
          n_fail++;
          $display("FAIL b2b_rdata cycle %0d: got %h want %h", k, rdata[1], (k == 0) ? v1 : v2);
        end
      end
      if (k == 0) addr[1] = 32'h44;
      if (k == 2) rd[1] = 1'b0;
      #1;
      n_cmp++;
      if (stall[1] !== (rd[1] & ~exp_rdy)) begin
        n_fail++;
        $display("FAIL b2b_stall cycle %0d: got %b want %b", k, stall[1], rd[1] & ~exp_rdy);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ready[1] !== 1'b0 || stall[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: ready=%b stall=%b want 0/0", ready[1], stall[1]);
    end
    last_rd[1] = v2;
  endtask

  task automatic test_random();
    int          pool [8];
    int          op;
    int          j;
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        pool[i] = int'($urandom_range(0, 1023));
        access(s, 1'b1, 1'b0, 32'(pool[i]) << 2, $urandom, "rnd_fill");
      end
      for (int i = 0; i < 30; i++) begin
        op = int'($urandom_range(0, 3));
        j  = int'($urandom_range(0, 7));
        a  = ($urandom & 32'hFFFF_F000) | (32'(pool[j]) << 2) | 32'($urandom_range(0, 3));
        access(s, op >= 2, op != 2, a, $urandom, "rnd_op");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_simultaneous();
    test_reset_midop();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
